// File: rtl/block_packer.sv
// ---------------------------------------------------------------------------
// block_packer
//   Packs variable-length byte fragments into contiguous DATA_W-bit blocks.
//   Fragments are MSB-aligned (byte 0 = in_data[DATA_W-1 -: 8]).
//   The end of a message is padded:
//     PAD_MODE 0 : zero padding
//     PAD_MODE 1 : 0x80 followed by zeros (ISO/IEC 7816-4)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. A producer holds valid and its payload steady until that edge.
//   in_ready is combinational from state, out_valid and out_ready. The
//   output payload is registered and held while out_valid=1 and out_ready=0.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     fragment present
//   in_ready     fragment accepted when in_valid & in_ready
//   in_data      fragment bytes, MSB-aligned
//   in_nbytes    valid byte count, 0..BYTES (larger values clamp to BYTES)
//   in_last      fragment ends the message
//   out_valid    block present
//   out_ready    block consumed when out_valid & out_ready
//   out_data     packed block, MSB-aligned
//   out_nbytes   message bytes in the block, padding excluded
//   out_last     final block of the message
//   dbg_state    FSM state (0 = ACCUM, 1 = FLUSH)
//   dbg_acc_cnt  residual bytes held in the accumulator
// ---------------------------------------------------------------------------
module block_packer #(
   parameter  int DATA_W   = 128,
   parameter  int PAD_MODE = 0,
   localparam int BYTES    = DATA_W / 8,
   localparam int NB_W     = $clog2(BYTES) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [NB_W-1:0]   in_nbytes,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [NB_W-1:0]   out_nbytes,
   output logic              out_last,
   output logic              dbg_state,
   output logic [NB_W-1:0]   dbg_acc_cnt
);

   typedef enum logic {
      ACCUM = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t              state;
   logic [DATA_W-1:0]   acc;       // residual bytes, MSB-aligned, zero beyond acc_cnt
   logic [NB_W-1:0]     acc_cnt;

   logic [NB_W-1:0]     n_clamp;
   logic [DATA_W-1:0]   in_mask;
   logic [DATA_W-1:0]   in_masked;
   logic [2*DATA_W-1:0] comb;
   logic [NB_W:0]       total;
   logic [NB_W-1:0]     rem;
   logic                full;
   logic                out_free;
   logic                accept;

   // Adds the pad marker at byte position cnt. Bytes at and after cnt are
   // already zero because the accumulator and masked input keep that invariant.
   function automatic logic [DATA_W-1:0] pad_block(input logic [DATA_W-1:0] blk,
                                                   input logic [NB_W-1:0]   cnt);
      logic [DATA_W-1:0] marker;
      marker = {8'h80, {(DATA_W-8){1'b0}}} >> {cnt, 3'b000};
      if (PAD_MODE == 1) begin
         return blk | marker;
      end
      return blk;
   endfunction

   always_comb begin
      n_clamp   = (in_nbytes > NB_W'(BYTES)) ? NB_W'(BYTES) : in_nbytes;
      // Keep only the first n_clamp bytes; a shift of DATA_W yields all ones.
      in_mask   = ~({DATA_W{1'b1}} >> {n_clamp, 3'b000});
      in_masked = in_data & in_mask;
      // Upper half: first BYTES combined bytes; lower half: spill-over.
      comb      = {acc, {DATA_W{1'b0}}} |
                  ({in_masked, {DATA_W{1'b0}}} >> {acc_cnt, 3'b000});
      total     = {1'b0, acc_cnt} + {1'b0, n_clamp};
      full      = (total >= (NB_W+1)'(BYTES));
      // total - BYTES is below BYTES, so the low bits carry the exact result.
      rem       = total[NB_W-1:0] - NB_W'(BYTES);
      out_free  = !out_valid || out_ready;
      in_ready  = rst_n && (state == ACCUM) && out_free;
      accept    = in_valid && in_ready;
   end

   assign dbg_state   = state;
   assign dbg_acc_cnt = acc_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ACCUM;
         acc        <= '0;
         acc_cnt    <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_nbytes <= '0;
         out_last   <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  if (full) begin
                     out_valid  <= 1'b1;
                     out_data   <= comb[2*DATA_W-1:DATA_W];
                     out_nbytes <= NB_W'(BYTES);
                     acc        <= comb[DATA_W-1:0];
                     acc_cnt    <= rem;
                     // A residual, or a mode-1 pad block, still has to follow.
                     if (in_last && (rem != '0 || PAD_MODE == 1)) begin
                        out_last <= 1'b0;
                        state    <= FLUSH;
                     end else begin
                        out_last <= in_last;
                     end
                  end else if (in_last) begin
                     out_valid  <= 1'b1;
                     out_data   <= pad_block(comb[2*DATA_W-1:DATA_W], total[NB_W-1:0]);
                     out_nbytes <= total[NB_W-1:0];
                     out_last   <= 1'b1;
                     acc        <= '0;
                     acc_cnt    <= '0;
                  end else begin
                     // Accepting implies the output register is free or draining.
                     out_valid <= 1'b0;
                     acc       <= comb[2*DATA_W-1:DATA_W];
                     acc_cnt   <= total[NB_W-1:0];
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            FLUSH: begin
               if (out_free) begin
                  out_valid  <= 1'b1;
                  out_data   <= pad_block(acc, acc_cnt);
                  out_nbytes <= acc_cnt;
                  out_last   <= 1'b1;
                  acc        <= '0;
                  acc_cnt    <= '0;
                  state      <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: doc/block_packer.md
BLOCK_PACKER -- requirements
Module: block_packer

Interface
REQ-001 Parameter DATA_W, default 128, output block width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter PAD_MODE, default 0, padding rule: 0 = zero pad; 1 = 0x80 then zeros (ISO/IEC 7816-4).
REQ-003 BYTES = DATA_W/8 and NB_W = clog2(BYTES)+1 SHALL be derived locally and SHALL NOT be overridable.
REQ-004 Timing: one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  fragment present.
REQ-008 in_ready  output  1  fragment accepted when in_valid and in_ready are both 1.
REQ-009 in_data  input  DATA_W  fragment bytes, MSB-aligned; byte 0 = bits [DATA_W-1:DATA_W-8].
REQ-010 in_nbytes  input  NB_W  valid byte count of the fragment, 0..BYTES.
REQ-011 in_last  input  1  fragment ends the message.
REQ-012 out_valid  output  1  block present.
REQ-013 out_ready  input  1  block consumed when out_valid and out_ready are both 1.
REQ-014 out_data  output  DATA_W  packed block, MSB-aligned.
REQ-015 out_nbytes  output  NB_W  message bytes in the block, excluding padding.
REQ-016 out_last  output  1  final block of the message.

Function
REQ-017 Fragments SHALL be concatenated byte-wise in arrival order into contiguous DATA_W blocks; bytes of in_data beyond in_nbytes SHALL be ignored.
REQ-018 in_nbytes > BYTES SHALL be treated as BYTES.
REQ-019 An accumulator SHALL hold 0..BYTES-1 residual bytes (acc_cnt) between beats.
REQ-020 States: ACCUM (accepting) and FLUSH (residual or pad block pending, not accepting).
REQ-021 in_ready SHALL be 1 only in ACCUM and only when the output register is empty or out_ready=1 in the same cycle.
REQ-022 On accept with acc_cnt+in_nbytes >= BYTES: out_data = first BYTES combined bytes, out_nbytes = BYTES, out_valid = 1 the next cycle; the remainder SHALL go to the accumulator.
REQ-023 On accept with acc_cnt+in_nbytes < BYTES and in_last=0: bytes SHALL be appended and no block emitted.
REQ-024 in_last with total < BYTES: one padded block SHALL be emitted next cycle with out_last=1 and out_nbytes=total; this includes total=0, which gives an all-pad block with out_nbytes=0.
REQ-025 in_last with remainder > 0 after a full block: the full block SHALL be emitted with out_last=0, then FLUSH SHALL emit the padded remainder with out_last=1.
REQ-026 in_last with remainder = 0: PAD_MODE 0 sets out_last=1 on the full block; PAD_MODE 1 sets out_last=0 and FLUSH SHALL emit a block 0x80 followed by zeros with out_nbytes=0 and out_last=1.
REQ-027 PAD_MODE 0 pad bytes SHALL be 0x00; PAD_MODE 1 SHALL place 0x80 in byte out_nbytes and 0x00 after it.
REQ-028 FLUSH SHALL load its block when the output register is empty or drains, then return to ACCUM with acc_cnt=0.
REQ-029 Latency from accept to out_valid SHALL be exactly 1 cycle when the output register is free.
REQ-030 While out_valid=1 and out_ready=0, out_data, out_nbytes and out_last SHALL hold stable.
REQ-031 Full throughput: one block per cycle with out_ready held 1, except FLUSH bubbles.

Reset
REQ-032 rst_n=0 SHALL immediately force out_valid=0, out_data=0, out_nbytes=0, out_last=0, in_ready=0, acc_cnt=0, state=ACCUM.
REQ-033 After reset deasserts, in_ready SHALL be 1 on the first rising edge.
REQ-034 Reset mid-message SHALL discard all residual bytes and any pending block, with no partial output afterwards.

Verification
REQ-035 PAD_MODE 0: one beat of 16 bytes 0x00..0x0F with in_last=1 -> one block 000102..0F, nbytes=16, last=1.
REQ-036 PAD_MODE 0: 8 bytes 0x11.., then 8 bytes 0x22.. with in_last=1 -> one block 1111111111111111_2222222222222222, last=1.
REQ-037 PAD_MODE 1: 12 bytes 0xAA then 8 bytes 0xBB with in_last=1 -> block 12xAA+4xBB (last=0), then 4xBB,0x80,11x00 with nbytes=4 and last=1.
REQ-038 PAD_MODE 1: 16 bytes with in_last=1 -> data block with last=0, then 0x80 followed by 15x00 with nbytes=0 and last=1.
REQ-039 Random out_ready backpressure over 1000 random fragments -> output byte stream matches a reference concatenation; outputs stay stable while stalled; no loss or duplication.
REQ-040 rst_n pulsed low while acc_cnt=5 and a block is stalled -> out_valid=0 at once; a following 3-byte last fragment yields nbytes=3 holding only the new bytes.
